sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
- Shares the single external SRAM between instruction fetch (IF) and the MEM-stage load/store port of the 16-bit pipeline.
- Grants one requester at a time and sequences the multi-cycle SRAM read/write strobes.
- Returns data with a one-cycle ack and raises a stall request to the pipeline controller while any access is outstanding.
- Sits between the core and the top-level SRAM pins.

Parameters:
ADDR_W, 18, SRAM word-address width
DATA_W, 16, data word width
RD_CYCLES, 2, cycles oe_n held low before data is sampled (min 1)
WR_CYCLES, 2, cycles we_n held low (min 1)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low
if_req  in  1  IF fetch request, held until if_ack
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched word, valid when if_ack=1
if_ack  out  1  one-cycle completion pulse for IF
mem_req  in  1  MEM access request, held until mem_ack
mem_we  in  1  1=store, 0=load
mem_addr  in  ADDR_W  load/store address
mem_wdata  in  DATA_W  store data
mem_rdata  out  DATA_W  load data, valid when mem_ack=1
mem_ack  out  1  one-cycle completion pulse for MEM
stall_req  out  1  pipeline stall request
sram_addr  out  ADDR_W  SRAM address
sram_dq_o  out  DATA_W  SRAM write data
sram_dq_oe  out  1  1=drive data bus
sram_dq_i  in  DATA_W  SRAM read data
sram_ce_n  out  1  chip enable, active-low
sram_oe_n  out  1  output enable, active-low
sram_we_n  out  1  write enable, active-low

Behaviour:
Reset (rst=0 at a clock edge):
- State goes to IDLE.
- sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dq_oe=0.
- sram_addr=0, sram_dq_o=0, if_rdata=0, mem_rdata=0.
- if_ack=0, mem_ack=0.
- Reset aborts any in-flight access immediately; no ack is issued for the aborted access.

FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.

IDLE:
- If mem_req=1, grant MEM: latch addr, we and wdata into internal registers, set owner=MEM.
- Else if if_req=1, grant IF: latch addr, owner=IF, we=0.
- MEM has fixed priority because it holds the older instruction. IF cannot starve: a new MEM request needs the pipeline to advance, and the pipeline stays stalled until the pending fetch completes.
- Grant goes to RD if the latched we=0, otherwise to WR_SETUP.

RD:
- ce_n=0, oe_n=0, dq_oe=0, counter counts RD_CYCLES.
- On the last RD cycle, register sram_dq_i into the owner's rdata, then go to DONE.

WR_SETUP (1 cycle):
- ce_n=0, we_n=1, dq_oe=1, address and data driven.

WR_PULSE:
- we_n=0 for WR_CYCLES cycles, address and data held stable.

WR_HOLD (1 cycle):
- we_n=1, dq_oe still 1, then go to DONE.

DONE (1 cycle):
- ce_n=1, oe_n=1, dq_oe=0.
- Owner's ack=1; the other ack stays 0. Next state is IDLE.

Latencies:
- Load or fetch: request seen in IDLE at cycle T, ack at T+RD_CYCLES+1.
- Store: ack at T+WR_CYCLES+3.

Requester rules:
- A requester still asserting req in the cycle after its ack starts a new request.
- Request inputs are ignored outside IDLE; their latched copies are used for the whole access.

Data outputs:
- rdata holds its value until the next read completes for that owner.
- rdata is not updated on stores.

stall_req (combinational):
- stall_req = (if_req & ~if_ack) | (mem_req & ~mem_ack).
- It is therefore 0 in the DONE cycle if only the acked requester was pending.

Bus safety:
- sram_dq_oe and sram_oe_n=0 are never asserted in the same cycle.
- sram_we_n is only low in WR_PULSE.

Counter:
- Width is clog2(max(RD_CYCLES, WR_CYCLES))+1.
- Reloaded on every state entry.

Test Plan:
1. Reset mid-write: hold rst=0 during WR_PULSE → next edge we_n=1, ce_n=1, dq_oe=0, no mem_ack; IDLE afterwards.
2. IF read only: if_req=1, if_addr=0x00010, SRAM model returns 0x4C21 → oe_n low 2 cycles, if_ack pulse at T+3, if_rdata=0x4C21, stall_req 1 until the ack cycle.
3. MEM store: mem_we=1, addr=0x0BF00, wdata=0xBEEF → WR_SETUP, 2 cycles we_n=0, WR_HOLD, mem_ack at T+5; model memory[0x0BF00]=0xBEEF; data stable for the whole window.
4. Simultaneous requests: if_req=1 with addr 0x00020, mem_req=1 load with addr 0x08000 → MEM served first (mem_ack at T+3), then IF (if_ack at T+7); stall_req stays 1 until if_ack.
5. Back-to-back fetches: if_req held high for addresses 0x0..0x3 → one ack every 4 cycles, correct data each time, no gap beyond the IDLE cycle.
6. Contention check over a random 2000-cycle mix of requests → assertion never fires for sram_dq_oe & ~sram_oe_n; exactly one ack per granted request.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one asynchronous SRAM between instruction fetch
// and the MEM-stage load/store port. It serves one access at a time, with a
// fixed priority for MEM. It sequences the oe_n/we_n strobes, returns data
// with a one-cycle ack and requests a pipeline stall while any request is
// outstanding.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | bus quiet, arbitrate between MEM and IF requests
// RD       | ce_n/oe_n low for RD_CYCLES, sample dq_i on the last cycle
// WR_SETUP | address/data driven, we_n still high
// WR_PULSE | we_n low for WR_CYCLES
// WR_HOLD  | we_n high again, data still driven
// DONE     | bus released, one-cycle ack to the owner
module sram_bus_arbiter #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              stall_req,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              owner_mem_q, owner_mem_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  // State register plus latched request and returned data
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      owner_mem_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      owner_mem_q <= owner_mem_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Next-state: arbitration, strobe-length down-counter and read capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    owner_mem_d = owner_mem_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        // MEM holds the older instruction, so it wins ties
        if (mem_req) begin
          owner_mem_d = 1'b1;
          addr_d      = mem_addr;
          we_d        = mem_we;
          wdata_d     = mem_wdata;
          state_d     = mem_we ? S_WR_SETUP : S_RD;
          cnt_d       = mem_we ? '0 : RD_LOAD;
        end else if (if_req) begin
          owner_mem_d = 1'b0;
          addr_d      = if_addr;
          we_d        = 1'b0;
          state_d     = S_RD;
          cnt_d       = RD_LOAD;
        end
      end
      S_RD: begin
        if (cnt_q == '0) begin
          if (owner_mem_q) mem_rdata_d = sram_dq_i;
          else             if_rdata_d  = sram_dq_i;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = WR_LOAD;
      end
      S_WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR_HOLD: begin
        state_d = S_DONE;
        cnt_d   = '0;
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: SRAM strobes and acks decoded from the current state
  always_comb begin
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    if_ack     = 1'b0;
    mem_ack    = 1'b0;
    unique case (state_q)
      S_RD: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        sram_ce_n  = 1'b0;
        sram_dq_oe = 1'b1;
      end
      S_WR_PULSE: begin
        sram_ce_n  = 1'b0;
        sram_we_n  = 1'b0;
        sram_dq_oe = 1'b1;
      end
      S_DONE: begin
        if_ack  = ~owner_mem_q;
        mem_ack = owner_mem_q;
      end
      default: ;
    endcase
  end

  assign sram_addr = addr_q;
  assign sram_dq_o = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign stall_req = (if_req & ~if_ack) | (mem_req & ~mem_ack);

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: SRAM behavioural model, directed scenarios and
// a random request mix checked against a transaction-level reference.
module tb_sram_bus_arbiter;

  localparam int RD = 2;
  localparam int WR = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [17:0] if_addr, mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] if_rdata, mem_rdata;
  logic        if_ack, mem_ack, stall_req;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_i = 16'h0;
  logic        sram_ce_n, sram_oe_n, sram_we_n;

  sram_bus_arbiter #(.ADDR_W(18), .DATA_W(16), .RD_CYCLES(RD), .WR_CYCLES(WR)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_req(stall_req),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // SRAM contents (device side) and expected contents (reference side)
  logic [15:0] sram_mem [int];
  logic [15:0] ref_mem  [int];

  function automatic logic [15:0] init_val(int a);
    return 16'((a * 40503) ^ 23130);
  endfunction

  function automatic logic [15:0] sram_rd(logic [17:0] a);
    if (sram_mem.exists(int'(a))) return sram_mem[int'(a)];
    return init_val(int'(a));
  endfunction

  function automatic logic [15:0] ref_rd(logic [17:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(int'(a));
  endfunction

  always @(negedge clk)
    sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_rd(sram_addr) : 16'hDEAD;

  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram_mem[int'(sram_addr)] = sram_dq_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: at most one access in flight, timing from the latency rules
  int cyc, free_at, if_ack_at, mem_ack_at;
  int ce_lo, ce_hi, oe_lo, oe_hi, we_lo, we_hi, dq_lo, dq_hi;
  logic [17:0] cur_addr;
  logic [15:0] cur_wdata, if_pend, mem_pend, exp_if_rd, exp_mem_rd;
  bit          mem_pend_load;
  int          n_grant, n_ack;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic bit inw(int lo, int hi);
    return (cyc >= lo) && (cyc <= hi);
  endfunction

  task automatic clear_windows();
    ce_lo = -1; ce_hi = -2; oe_lo = -1; oe_hi = -2;
    we_lo = -1; we_hi = -2; dq_lo = -1; dq_hi = -2;
  endtask

  // One clock cycle: check combinational/bus outputs, advance the reference,
  // cross the edge, then check acks and returned data.
  task automatic cycle();
    int lat;
    #1;
    chk("stall_req", stall_req, (if_req && cyc != if_ack_at) || (mem_req && cyc != mem_ack_at));
    chk("bus_contention", sram_dq_oe & ~sram_oe_n, 0);
    chk("ce_n", sram_ce_n, !inw(ce_lo, ce_hi));
    chk("oe_n", sram_oe_n, !inw(oe_lo, oe_hi));
    chk("we_n", sram_we_n, !inw(we_lo, we_hi));
    chk("dq_oe", sram_dq_oe, inw(dq_lo, dq_hi));
    if (inw(ce_lo, ce_hi)) chk("sram_addr", sram_addr, cur_addr);
    if (inw(dq_lo, dq_hi)) chk("sram_dq_o", sram_dq_o, cur_wdata);
    if (!rst) begin
      free_at = cyc + 1; if_ack_at = -1; mem_ack_at = -1;
      clear_windows();
      exp_if_rd = '0; exp_mem_rd = '0;
    end else if (cyc >= free_at && (mem_req || if_req)) begin
      n_grant++;
      clear_windows();
      if (mem_req) begin
        cur_addr = mem_addr;
        if (mem_we) begin
          lat = WR + 3;
          cur_wdata = mem_wdata;
          ref_mem[int'(mem_addr)] = mem_wdata;
          mem_pend_load = 0;
          dq_lo = cyc + 1; dq_hi = cyc + lat - 1;
          we_lo = cyc + 2; we_hi = cyc + 1 + WR;
        end else begin
          lat = RD + 1;
          mem_pend = ref_rd(mem_addr);
          mem_pend_load = 1;
          oe_lo = cyc + 1; oe_hi = cyc + RD;
        end
        mem_ack_at = cyc + lat;
      end else begin
        cur_addr = if_addr;
        lat = RD + 1;
        if_pend = ref_rd(if_addr);
        if_ack_at = cyc + lat;
        oe_lo = cyc + 1; oe_hi = cyc + RD;
      end
      ce_lo = cyc + 1; ce_hi = cyc + lat - 1;
      free_at = cyc + lat + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("if_ack", if_ack, cyc == if_ack_at);
    chk("mem_ack", mem_ack, cyc == mem_ack_at);
    n_ack += int'(if_ack) + int'(mem_ack);
    if (cyc == if_ack_at) exp_if_rd = if_pend;
    if (cyc == mem_ack_at && mem_pend_load) exp_mem_rd = mem_pend;
    chk("if_rdata", if_rdata, exp_if_rd);
    chk("mem_rdata", mem_rdata, exp_mem_rd);
  endtask

  task automatic wait_ack(input bit is_mem, input int budget);
    int n = 0;
    bit seen = 0;
    while (!seen && n < budget) begin
      cycle();
      n++;
      seen = is_mem ? mem_ack : if_ack;
    end
    if (!seen) chk(is_mem ? "mem_ack_timeout" : "if_ack_timeout", 0, 1);
  endtask

  initial begin
    int t0, prev;
    rst = 1'b0; if_req = 0; mem_req = 0; mem_we = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    cyc = 0; free_at = 0; if_ack_at = -1; mem_ack_at = -1;
    clear_windows();
    cur_addr = '0; cur_wdata = '0; if_pend = '0; mem_pend = '0;
    exp_if_rd = '0; exp_mem_rd = '0; mem_pend_load = 0;
    n_grant = 0; n_ack = 0;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_ce_n", sram_ce_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dq_o", sram_dq_o, 0);
    chk("rst_acks", {if_ack, mem_ack}, 0);
    cycle();
    rst = 1'b1;
    cycle();

    // IF read only
    sram_mem[16'h0010] = 16'h4C21;
    ref_mem[16'h0010]  = 16'h4C21;
    if_addr = 18'h00010; if_req = 1;
    t0 = cyc;
    wait_ack(0, 10);
    chk("if_read_latency", cyc, t0 + 3);
    chk("if_read_data", if_rdata, 16'h4C21);
    if_req = 0;
    cycle();

    // MEM store
    mem_req = 1; mem_we = 1; mem_addr = 18'h0BF00; mem_wdata = 16'hBEEF;
    t0 = cyc;
    wait_ack(1, 12);
    chk("store_latency", cyc, t0 + 5);
    mem_req = 0; mem_we = 0;
    cycle();
    chk("store_mem", sram_rd(18'h0BF00), 16'hBEEF);

    // Simultaneous: MEM load first, then IF
    if_req = 1; if_addr = 18'h00020;
    mem_req = 1; mem_we = 0; mem_addr = 18'h08000;
    t0 = cyc;
    wait_ack(1, 10);
    chk("simul_mem_latency", cyc, t0 + 3);
    chk("simul_mem_data", mem_rdata, ref_rd(18'h08000));
    mem_req = 0;
    wait_ack(0, 10);
    chk("simul_if_latency", cyc, t0 + 7);
    chk("simul_if_data", if_rdata, ref_rd(18'h00020));
    if_req = 0;
    cycle();

    // Back-to-back fetches with if_req held
    if_req = 1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      if_addr = 18'(k);
      wait_ack(0, 10);
      if (k > 0) chk("b2b_spacing", cyc - prev, 4);
      chk("b2b_data", if_rdata, ref_rd(18'(k)));
      prev = cyc;
    end
    if_req = 0;
    cycle();

    // Reset in the middle of a write pulse
    mem_req = 1; mem_we = 1; mem_addr = 18'h00300; mem_wdata = 16'h1234;
    cycle();
    cycle();
    cycle();
    chk("midwr_in_pulse", sram_we_n, 0);
    rst = 0; mem_req = 0; mem_we = 0;
    cycle();
    chk("midwr_we_n", sram_we_n, 1);
    chk("midwr_ce_n", sram_ce_n, 1);
    chk("midwr_dq_oe", sram_dq_oe, 0);
    chk("midwr_no_ack", mem_ack, 0);
    rst = 1;
    for (int k = 0; k < 6; k++) cycle();

    // Random mix; reference checks timing, strobes, data and ack count
    n_grant = 0; n_ack = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!if_req || if_ack) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = 18'h200 + 18'($urandom_range(0, 31));
      end
      if (!mem_req || mem_ack) begin
        mem_req   = ($urandom_range(0, 2) == 0);
        mem_we    = $urandom_range(0, 1) == 1;
        mem_addr  = 18'h200 + 18'($urandom_range(0, 31));
        mem_wdata = 16'($urandom);
      end
      cycle();
    end
    if_req = 0; mem_req = 0;
    for (int k = 0; k < 12; k++) cycle();
    chk("ack_per_grant", n_ack, n_grant);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
